// File: rtl/bkram_pkg.sv
// rtl/bkram_pkg.sv - shared FSM type, format header and LBA helper for the backup-RAM controller
package bkram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER_REQ,
    ST_XFER_WAIT,
    ST_FORMAT
  } bk_state_t;

  localparam int BK_HDR_LEN = 4;
  localparam logic [15:0] BK_HDR [BK_HDR_LEN] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
  localparam int BK_WORDS_PER_SECT = 256;

  function automatic logic [31:0] bk_lba(input logic [31:0] slot, input logic [31:0] sector,
                                         input logic [31:0] sectors);
    return slot * sectors + sector;
  endfunction

endpackage

// File: rtl/bkram_edge.sv
// rtl/bkram_edge.sv - registered rising/falling edge detector for a bundle of level inputs
module bkram_edge #(
  parameter int W = 1
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) d_q <= '0;
    else          d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/bkram_sd_ctrl.sv
// rtl/bkram_sd_ctrl.sv - backup-RAM save/load/format controller between save RAM port B and hps_io SD
// Define BKRAM_AUTOSAVE_EN for dirty tracking and OSD-triggered autosave.
module bkram_sd_ctrl
  import bkram_pkg::*;
#(
  parameter int SECTORS   = 16,
  parameter int SLOTS     = 1,
  parameter int FMT_WORDS = 4,
  parameter int FMT_CLEAR = 0,
  localparam int SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int RA_W     = $clog2(SECTORS) + 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic              img_size_nz,
  input  logic              downloading,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic              autosave_en,
  input  logic              osd_open,
  input  logic              core_wr,
  input  logic [SLOT_W-1:0] slot,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [7:0]        sd_buff_addr,
  input  logic [15:0]       sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [15:0]       sd_buff_din,
  output logic [RA_W-1:0]   ram_addr,
  output logic [15:0]       ram_din,
  output logic              ram_we,
  input  logic [15:0]       ram_q,
  output logic              bk_ena,
  output logic              bk_loading,
  output logic              bk_busy,
  output logic              bk_pending
);

  localparam int SECT_W   = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam int FMT_LAST = (FMT_CLEAR != 0) ? SECTORS * BK_WORDS_PER_SECT - 1 : FMT_WORDS - 1;

  bk_state_t           state_q, state_d;
  logic [SLOT_W-1:0]   slot_q;
  logic                load_q;
  logic [SECT_W-1:0]   sector_q;
  logic [RA_W-1:0]     word_q;
  logic                bk_ena_q;
  logic                pending;
  logic                start_xfer, start_load;
  logic                autosave_trig;

  logic [4:0] rise_v, fall_v;
  logic       load_rise, save_rise, format_rise, ack_rise, ack_fall, dl_rise, dl_fall;
  logic       unused_req_fall;

  bkram_edge #(.W(5)) u_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d_i     ({downloading, sd_ack, format_req, save_req, load_req}),
    .rise_o  (rise_v),
    .fall_o  (fall_v)
  );

  assign load_rise       = rise_v[0];
  assign save_rise       = rise_v[1];
  assign format_rise     = rise_v[2];
  assign ack_rise        = rise_v[3];
  assign ack_fall        = fall_v[3];
  assign dl_rise         = rise_v[4];
  assign dl_fall         = fall_v[4];
  assign unused_req_fall = ^fall_v[2:0];

  logic last_sector, last_word, xfer_done, fmt_done;
  assign last_sector = (sector_q == SECT_W'(SECTORS - 1));
  assign last_word   = (word_q == RA_W'(FMT_LAST));
  assign xfer_done   = (state_q == ST_XFER_WAIT) && ack_fall && last_sector;
  assign fmt_done    = (state_q == ST_FORMAT) && last_word;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Requests arriving outside IDLE fall through every branch and are lost.
  always_comb begin
    state_d    = state_q;
    start_xfer = 1'b0;
    start_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bk_ena_q && ((dl_fall && img_size_nz) || load_rise)) begin
          state_d    = ST_XFER_REQ;
          start_xfer = 1'b1;
          start_load = 1'b1;
        end else if (bk_ena_q && (save_rise || autosave_trig)) begin
          state_d    = ST_XFER_REQ;
          start_xfer = 1'b1;
        end else if (format_rise) begin
          state_d = ST_FORMAT;
        end
      end
      ST_XFER_REQ:  if (ack_rise) state_d = ST_XFER_WAIT;
      ST_XFER_WAIT: if (ack_fall) state_d = last_sector ? ST_IDLE : ST_XFER_REQ;
      ST_FORMAT:    if (fmt_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_lba      = '0;
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    sd_buff_din = '0;
    ram_addr    = '0;
    ram_din     = '0;
    ram_we      = 1'b0;
    bk_loading  = 1'b0;
    bk_busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_XFER_REQ, ST_XFER_WAIT: begin
        sd_lba      = bk_lba(32'(slot_q), 32'(sector_q), 32'(SECTORS));
        sd_rd       = (state_q == ST_XFER_REQ) && load_q;
        sd_wr       = (state_q == ST_XFER_REQ) && !load_q;
        sd_buff_din = ram_q;
        ram_addr    = RA_W'({sector_q, sd_buff_addr});
        ram_din     = sd_buff_dout;
        ram_we      = sd_buff_wr & sd_ack & load_q;
        bk_loading  = load_q;
      end
      ST_FORMAT: begin
        ram_addr = word_q;
        ram_din  = (word_q < RA_W'(FMT_WORDS)) ? BK_HDR[word_q[1:0]] : 16'h0000;
        ram_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      slot_q   <= '0;
      load_q   <= 1'b0;
      sector_q <= '0;
      word_q   <= '0;
    end else begin
      if (start_xfer) begin
        slot_q   <= slot;
        load_q   <= start_load;
        sector_q <= '0;
      end else if ((state_q == ST_XFER_WAIT) && ack_fall && !last_sector) begin
        sector_q <= sector_q + 1'b1;
      end
      if (state_q == ST_FORMAT) word_q <= word_q + 1'b1;
      else                      word_q <= '0;
    end
  end

  // A mount during the download wins over the download-start clear in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)                                        bk_ena_q <= 1'b0;
    else if (downloading && img_mounted && !img_readonly) bk_ena_q <= 1'b1;
    else if (dl_rise)                                     bk_ena_q <= 1'b0;
  end

`ifdef BKRAM_AUTOSAVE_EN
  logic pending_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n)                                      pending_q <= 1'b0;
    else if (xfer_done && !load_q)                     pending_q <= 1'b0;
    else if ((core_wr && bk_ena_q && !osd_open) || fmt_done) pending_q <= 1'b1;
  end

  assign pending       = pending_q;
  assign autosave_trig = pending_q & osd_open & autosave_en;
`else
  logic unused_autosave;

  assign pending         = 1'b0;
  assign autosave_trig   = 1'b0;
  assign unused_autosave = ^{autosave_en, osd_open, core_wr, xfer_done};
`endif

  assign bk_ena     = bk_ena_q;
  assign bk_pending = pending;

endmodule

// File: doc/bkram_sd_ctrl.md
Name: bkram_sd_ctrl

Overview:
- Parametrised backup-RAM persistence controller between the core's dual-port save RAM (port B) and the hps_io SD block interface.
- Generalises the single-slot, fixed-16-sector save/load logic to N sectors and M save slots.
- Adds a sequencer-driven format with optional full clear, dirty tracking, and OSD-triggered autosave.
- Sits in the emu top level beside hps_io; its bk_loading output holds the core in reset during loads.

Parameters:
- SECTORS, 16, 512-byte sectors per save image; power of two, 1..256.
- SLOTS, 1, independent save images on the mounted file; power of two, 1..16.
- FMT_WORDS, 4, header words written by format, taken from the package constant BK_HDR.
- FMT_CLEAR, 0, 1 = format zero-fills all words after the header.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- img_mounted  in  1  pulse: save image mounted
- img_readonly  in  1  mounted image is read-only
- img_size_nz  in  1  mounted image size is non-zero
- downloading  in  1  cart download in progress
- load_req  in  1  level; rising edge starts a load
- save_req  in  1  level; rising edge starts a save
- format_req  in  1  level; rising edge starts a format
- autosave_en  in  1  OSD autosave option
- osd_open  in  1  OSD visible
- core_wr  in  1  core wrote save RAM (port A)
- slot  in  SLOT_W  slot select, sampled at operation start; SLOT_W = max(1, clog2(SLOTS))
- sd_lba  out  32  sector address
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_ack  in  1  hps_io acknowledge
- sd_buff_addr  in  8  word index within sector
- sd_buff_dout  in  16  SD data to RAM
- sd_buff_wr  in  1  SD data strobe
- sd_buff_din  out  16  RAM data to SD
- ram_addr  out  RA_W  port-B address; RA_W = clog2(SECTORS) + 8
- ram_din  out  16  port-B write data
- ram_we  out  1  port-B write enable
- ram_q  in  16  port-B read data
- bk_ena  out  1  writable image present
- bk_loading  out  1  load in progress
- bk_busy  out  1  any operation in progress
- bk_pending  out  1  unsaved writes exist

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE. Reset taken mid-operation aborts immediately and drops sd_rd/sd_wr.
- bk_ena:
  - Cleared on the rising edge of downloading.
  - Set when downloading and img_mounted and not img_readonly.
- FSM states: IDLE, XFER_REQ, XFER_WAIT, FORMAT.
- Edge detectors register load_req, save_req and format_req every cycle. Edges arriving in a non-IDLE state are dropped, not queued.
- IDLE priority, all gated by bk_ena except format:
  1. Falling edge of downloading with img_size_nz: load.
  2. load_req edge: load.
  3. save_req edge, or the autosave trigger: save.
  4. format_req edge: format.
- Load/save start:
  - Latch slot and the direction (load or save); sector counter = 0.
  - bk_loading = 1 for a load; bk_busy = 1.
  - Go to XFER_REQ.
- XFER_REQ:
  - Drive sd_lba = slot*SECTORS + sector, zero-extended.
  - Assert sd_rd for a load, sd_wr for a save.
  - Both requests clear on the first cycle sd_ack is seen high (rising edge); then go to XFER_WAIT.
- XFER_WAIT, on sd_ack falling edge:
  - Last sector (sector == SECTORS-1): go to IDLE, clear bk_loading and bk_busy. A completed save clears bk_pending.
  - Otherwise: increment the sector counter and return to XFER_REQ. The next request is asserted one cycle after the falling edge.
- RAM routing during XFER:
  - ram_addr = {sector, sd_buff_addr}.
  - ram_din = sd_buff_dout.
  - ram_we = sd_buff_wr & sd_ack & load.
  - sd_buff_din = ram_q.
- FORMAT:
  - A word counter w runs 0..last, writing one word per cycle with ram_we = 1.
  - ram_din = BK_HDR[w] for w < FMT_WORDS, else 0.
  - last = FMT_WORDS-1, or SECTORS*256-1 when FMT_CLEAR = 1.
  - At completion: back to IDLE, and bk_pending is set.
- Outside XFER and FORMAT, ram_we = 0.
- Dirty tracking: bk_pending is set by core_wr when bk_ena and not osd_open. A set and a clear in the same cycle resolve to clear.
- Autosave trigger: bk_pending & osd_open & autosave_en, evaluated in IDLE only.
- sd_ack is ignored in IDLE. A stray ack causes no state change.

Optional Feature:
- Macro: BKRAM_AUTOSAVE_EN.
- Defined: dirty tracking and the autosave trigger as above.
- Undefined:
  - bk_pending is tied 0; autosave_en, osd_open and core_wr are unused.
  - Saves occur only on a save_req edge.
  - Format does not set pending.

Decomposition:
- Package bkram_pkg holds:
  - typedef bk_state_t (the FSM enum);
  - localparam BK_HDR (array of 16-bit words 16'h5548, 16'h4D42, 16'h8800, 16'h8010);
  - localparam BK_WORDS_PER_SECT = 256;
  - function bk_lba(slot, sector, SECTORS).
- One sub-module, bkram_edge (rising/falling edge detector), instantiated for the request inputs, sd_ack and downloading.

Test Plan:
- Load: SLOTS=4, slot=2, SECTORS=16, bk_ena=1, load_req pulse.
  - sd_lba steps 32..47.
  - One sd_rd per sector, cleared on ack rise.
  - 4096 ram_we strobes.
  - bk_loading drops after the ack fall of LBA 47.
- Save after core_wr: bk_pending=1.
  - save_req gives sd_wr for LBA 0..15; sd_buff_din tracks ram_q.
  - bk_pending = 0 at completion.
- Format, FMT_CLEAR=1, SECTORS=16:
  - ram writes 5548, 4D42, 8800, 8010 at addresses 0-3, then 0 at addresses 4..4095.
  - 4096 writes in 4096 cycles; bk_pending = 1 afterwards.
- Autosave: core_wr with osd_open=0, then osd_open=1 and autosave_en=1.
  - Save starts in IDLE; the same test with autosave_en=0 starts no save.
- Collision: save_req edge during a load.
  - Dropped; exactly 16 sd_rd and 0 sd_wr.
  - Simultaneous load_req and save_req edges in IDLE give a load.
- Abort: reset_n=0 during sector 5 of a save.
  - Next cycle sd_wr = 0, bk_busy = 0, sd_lba = 0; a subsequent load starts at LBA 0.
